// File: rtl/inst_queue.sv
// inst_queue: four-wide circular instruction queue between fetch and the four-slot decoder.
// Define INSTQ_PERF_EN to add the saturating starve_cycles output.
module inst_queue #(
    parameter  int DEPTH = 16,
    localparam int PTRW  = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            fetch_valid,
    input  logic [2:0]      fetch_cnt,
    input  logic [31:0]     fetch_inst0,
    input  logic [31:0]     fetch_inst1,
    input  logic [31:0]     fetch_inst2,
    input  logic [31:0]     fetch_inst3,
    output logic            fetch_ready,
    output logic            inst_en,
    output logic [31:0]     Inst1,
    output logic [31:0]     Inst2,
    output logic [31:0]     Inst3,
    output logic [31:0]     Inst4,
    output logic [2:0]      avail_cnt,
    input  logic [2:0]      dec_take,
    output logic [PTRW:0]   occupancy
`ifdef INSTQ_PERF_EN
    ,
    output logic [31:0]     starve_cycles
`endif
);
    localparam logic [PTRW:0] READY_MAX = (PTRW+1)'(DEPTH - 4);
    localparam logic [PTRW:0] FOUR      = (PTRW+1)'(4);

    logic [31:0]     r_mem [DEPTH];
    logic [PTRW-1:0] r_head;
    logic [PTRW-1:0] r_tail;
    logic [PTRW:0]   r_count;
    logic [31:0]     w_fin [4];
    logic [31:0]     w_rd  [4];
    logic [2:0]      w_wr_cnt;
    logic [2:0]      w_take;
    logic            w_cnt_ok;

    assign w_fin       = '{fetch_inst0, fetch_inst1, fetch_inst2, fetch_inst3};
    assign w_cnt_ok    = (fetch_cnt != 3'd0) && (fetch_cnt <= 3'd4);
    // Readiness uses registered count only, so a full packet always fits.
    assign fetch_ready = r_count <= READY_MAX;
    assign w_wr_cnt    = (fetch_valid && fetch_ready && w_cnt_ok) ? fetch_cnt : 3'd0;
    assign avail_cnt   = (r_count >= FOUR) ? 3'd4 : r_count[2:0];
    assign w_take      = (dec_take < avail_cnt) ? dec_take : avail_cnt;
    assign inst_en     = r_count != '0;
    assign occupancy   = r_count;

    always_comb begin
        for (int k = 0; k < 4; k++)
            w_rd[k] = (3'(k) < avail_cnt) ? r_mem[r_head + PTRW'(k)] : 32'h0;
    end

    assign Inst1 = w_rd[0];
    assign Inst2 = w_rd[1];
    assign Inst3 = w_rd[2];
    assign Inst4 = w_rd[3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PTRW'(w_take);
            r_tail  <= r_tail + PTRW'(w_wr_cnt);
            r_count <= r_count + (PTRW+1)'(w_wr_cnt) - (PTRW+1)'(w_take);
        end
    end

    // Storage is deliberately unreset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (rst_n && !flush)
            for (int k = 0; k < 4; k++)
                if (3'(k) < w_wr_cnt)
                    r_mem[r_tail + PTRW'(k)] <= w_fin[k];
    end

`ifdef INSTQ_PERF_EN
    logic [31:0] r_starve;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_starve <= '0;
        else if (r_count == '0 && !flush && r_starve != '1)
            r_starve <= r_starve + 32'd1;
    end

    assign starve_cycles = r_starve;
`endif
endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: directed plus short random scoreboard bench for inst_queue.
// Define INSTQ_PERF_EN for both files to also exercise starve_cycles.
module tb_inst_queue;
    localparam int DEPTH = 16;
    localparam int PTRW  = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          fetch_valid;
    logic [2:0]    fetch_cnt;
    logic [31:0]   fetch_inst0, fetch_inst1, fetch_inst2, fetch_inst3;
    logic          fetch_ready;
    logic          inst_en;
    logic [31:0]   Inst1, Inst2, Inst3, Inst4;
    logic [2:0]    avail_cnt;
    logic [2:0]    dec_take;
    logic [PTRW:0] occupancy;
    logic [31:0]   starve_cycles;

    int total = 0;
    int bad   = 0;
    logic [31:0] sb[$];
    logic [31:0] starve_m = 0;

    inst_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .fetch_valid(fetch_valid), .fetch_cnt(fetch_cnt),
        .fetch_inst0(fetch_inst0), .fetch_inst1(fetch_inst1),
        .fetch_inst2(fetch_inst2), .fetch_inst3(fetch_inst3),
        .fetch_ready(fetch_ready), .inst_en(inst_en),
        .Inst1(Inst1), .Inst2(Inst2), .Inst3(Inst3), .Inst4(Inst4),
        .avail_cnt(avail_cnt), .dec_take(dec_take), .occupancy(occupancy)
`ifdef INSTQ_PERF_EN
        , .starve_cycles(starve_cycles)
`endif
    );

`ifndef INSTQ_PERF_EN
    assign starve_cycles = 32'h0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] o[4];
        int n, av;
        n  = sb.size();
        av = n < 4 ? n : 4;
        o  = '{Inst1, Inst2, Inst3, Inst4};
        chk({tag, "_occ"}, 32'(occupancy), 32'(n));
        chk({tag, "_avail"}, 32'(avail_cnt), 32'(av));
        chk({tag, "_en"}, 32'(inst_en), 32'(n != 0));
        chk({tag, "_ready"}, 32'(fetch_ready), 32'(n <= DEPTH - 4));
        for (int k = 0; k < 4; k++)
            chk($sformatf("%s_inst%0d", tag, k + 1), o[k], k < av ? sb[k] : 32'h0);
`ifdef INSTQ_PERF_EN
        chk({tag, "_starve"}, starve_cycles, starve_m);
`endif
    endtask

    // One clock: drive, advance the model on the edge, then check.
    task automatic cyc(input string tag, input logic v, input logic [2:0] c,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] a2, input logic [31:0] a3,
                       input logic [2:0] t, input logic f);
        logic [31:0] d[4];
        int n, av, tk, wr;
        fetch_valid = v; fetch_cnt = c; dec_take = t; flush = f;
        fetch_inst0 = a0; fetch_inst1 = a1; fetch_inst2 = a2; fetch_inst3 = a3;
        @(posedge clk);
        d  = '{a0, a1, a2, a3};
        n  = sb.size();
        av = n < 4 ? n : 4;
        tk = int'(t) < av ? int'(t) : av;
        wr = (v && n <= DEPTH - 4 && c >= 1 && c <= 4) ? int'(c) : 0;
        if (rst_n) begin
            if (n == 0 && !f && starve_m != 32'hFFFF_FFFF) starve_m++;
            if (f) sb.delete();
            else begin
                for (int k = 0; k < tk; k++) void'(sb.pop_front());
                for (int k = 0; k < wr; k++) sb.push_back(d[k]);
            end
        end
        #1;
        fetch_valid = 1'b0; fetch_cnt = 3'd0; dec_take = 3'd0; flush = 1'b0;
        check_all(tag);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; fetch_valid = 1'b0; fetch_cnt = 3'd0; dec_take = 3'd0;
        fetch_inst0 = '0; fetch_inst1 = '0; fetch_inst2 = '0; fetch_inst3 = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        chk("reset_ready", 32'(fetch_ready), 32'd1);
        rst_n = 1'b1;
        repeat (4) cyc("idle", 0, 0, 0, 0, 0, 0, 0, 0);

        cyc("push4", 1, 4, 32'h11, 32'h22, 32'h33, 32'h44, 0, 0);
        chk("t1_i1", Inst1, 32'h11); chk("t1_i2", Inst2, 32'h22);
        chk("t1_i3", Inst3, 32'h33); chk("t1_i4", Inst4, 32'h44);
        chk("t1_avail", 32'(avail_cnt), 32'd4); chk("t1_occ", 32'(occupancy), 32'd4);
`ifdef INSTQ_PERF_EN
        chk("perf_starve5", starve_cycles, 32'd5);
        cyc("perf_hold", 0, 0, 0, 0, 0, 0, 0, 0);
        chk("perf_hold5", starve_cycles, 32'd5);
`endif

        cyc("swap4", 1, 4, 32'h1, 32'h2, 32'h3, 32'h4, 4, 0);
        cyc("push56", 1, 2, 32'h5, 32'h6, 0, 0, 0, 0);
        cyc("pushpop", 1, 2, 32'h7, 32'h8, 0, 0, 3, 0);
        chk("t2_i1", Inst1, 32'h4); chk("t2_i2", Inst2, 32'h5);
        chk("t2_i3", Inst3, 32'h6); chk("t2_i4", Inst4, 32'h7);
        chk("t2_occ", 32'(occupancy), 32'd5);

        cyc("fill9", 1, 4, 32'h9, 32'hA0, 32'hA1, 32'hA2, 0, 0);
        cyc("fill13", 1, 4, 32'hB0, 32'hB1, 32'hB2, 32'hB3, 0, 0);
        chk("full_ready", 32'(fetch_ready), 32'd0);
        cyc("full_push", 1, 4, 32'hDEAD, 32'hBEEF, 32'hCAFE, 32'hF00D, 0, 0);
        chk("full_occ", 32'(occupancy), 32'd13);
        cyc("pop1", 0, 0, 0, 0, 0, 0, 1, 0);
        chk("pop1_ready", 32'(fetch_ready), 32'd1);

        cyc("drain1", 1, 4, 32'hC0, 32'hC1, 32'hC2, 32'hC3, 4, 0);
        cyc("drain2", 1, 4, 32'hC4, 32'hC5, 32'hC6, 32'hC7, 4, 0);
        cyc("cnt5", 1, 5, 32'hE0, 32'hE1, 32'hE2, 32'hE3, 0, 0);
        cyc("cnt0", 1, 0, 32'hE0, 32'hE1, 32'hE2, 32'hE3, 0, 0);
        cyc("drain3", 1, 2, 32'hC8, 32'hC9, 0, 0, 4, 0);
        cyc("drain4", 0, 0, 0, 0, 0, 0, 4, 0);
        cyc("drain5", 0, 0, 0, 0, 0, 0, 4, 0);
        cyc("drain6", 0, 0, 0, 0, 0, 0, 4, 0);
        cyc("drain7", 0, 0, 0, 0, 0, 0, 4, 0);
        chk("drain_occ", 32'(occupancy), 32'd0);
        cyc("wrap", 1, 4, 32'hA, 32'hB, 32'hC, 32'hD, 0, 0);
        chk("wrap_i1", Inst1, 32'hA); chk("wrap_i2", Inst2, 32'hB);
        chk("wrap_i3", Inst3, 32'hC); chk("wrap_i4", Inst4, 32'hD);

        cyc("f8", 1, 4, 32'h100, 32'h101, 32'h102, 32'h103, 0, 0);
        cyc("f9", 1, 1, 32'h104, 0, 0, 0, 0, 0);
        chk("f9_occ", 32'(occupancy), 32'd9);
        cyc("flush", 1, 4, 32'h200, 32'h201, 32'h202, 32'h203, 2, 1);
        chk("flush_occ", 32'(occupancy), 32'd0);
        chk("flush_en", 32'(inst_en), 32'd0);
        chk("flush_i1", Inst1, 32'h0);
        chk("flush_i4", Inst4, 32'h0);

        cyc("push2", 1, 2, 32'h55, 32'h66, 0, 0, 0, 0);
        cyc("overtake", 0, 0, 0, 0, 0, 0, 4, 0);
        chk("overtake_occ", 32'(occupancy), 32'd0);
        cyc("empty_take", 0, 0, 0, 0, 0, 0, 3, 0);

        cyc("pre_rst", 1, 3, 32'h77, 32'h78, 32'h79, 0, 0, 0);
        #2;
        rst_n = 1'b0; fetch_valid = 1'b1; fetch_cnt = 3'd4;
        #1;
        sb.delete(); starve_m = 0;
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("held_rst");
        rst_n = 1'b1; fetch_valid = 1'b0; fetch_cnt = 3'd0;

        for (int i = 0; i < 60; i++)
            cyc("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 5)),
                $urandom, $urandom, $urandom, $urandom,
                3'($urandom_range(0, 4)), 1'($urandom_range(0, 15) == 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
